// File: rtl/fnd_pkg.sv
// Shared types and constants for the FND sharing block: FSM states, client ids and segment codes.
package fnd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MANUAL,
        ST_AUTO,
        ST_PREEMPT
    } fnd_state_e;

    localparam logic [1:0] CL_SW    = 2'd0;
    localparam logic [1:0] CL_WATCH = 2'd1;
    localparam logic [1:0] CL_ALERT = 2'd2;
    localparam logic [1:0] CL_NONE  = 2'd3;
    localparam logic [1:0] SW_AUTO  = 2'd3;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    // Common-anode codes with dp off; entry [15] is leftmost.
    localparam logic [15:0][7:0] SEG_LUT = {
        SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
        8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [2:0] client_onehot(input logic [1:0] c);
        return (c == CL_NONE) ? 3'b000 : (3'b001 << c);
    endfunction

endpackage

// File: rtl/fnd_seg_encoder.sv
// Combinational BCD + dp to active-low 8-bit segment pattern, with a forced-blank input.
module fnd_seg_encoder
    import fnd_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    always_comb begin
        if (blank) seg = SEG_BLANK;
        else       seg = {~dp, SEG_LUT[bcd][6:0]};
    end

endmodule

// File: rtl/fnd_share_arbiter.sv
// Shares one 4-digit FND between stopwatch, watch and sensor/alert clients with tear-free commits.
// Optional macro FND_BLANK_LEADING_ZERO_EN blanks leading zero digits of the displayed client.
module fnd_share_arbiter
    import fnd_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int SCAN_HZ   = 1000,
    parameter int ROTATE_MS = 2000,
    parameter int HOLD_MS   = 3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  sw_owner,
    input  logic [2:0]  req,
    input  logic        alert,
    input  logic [47:0] digits,
    input  logic [11:0] dp,
    output logic [2:0]  grant,
    output logic [3:0]  fnd_com,
    output logic [7:0]  fnd_data
);

    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int MS_DIV   = CLK_HZ / 1000;
    localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int MS_W     = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam int ROT_W    = (ROTATE_MS > 1) ? $clog2(ROTATE_MS) : 1;
    localparam int HOLD_W   = $clog2(HOLD_MS + 1);

    logic [SCAN_W-1:0] scan_cnt;
    logic [MS_W-1:0]   ms_cnt;
    logic              scan_tick;
    logic              ms_tick;

    fnd_state_e        state;
    logic [1:0]        tgt;
    logic [ROT_W-1:0]  rot_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              alert_q;
    logic              alert_rise;
    fnd_state_e        entry_state;
    logic [1:0]        entry_tgt;

    logic [1:0]        idx;
    logic [1:0]        idx_nxt;
    logic [1:0]        owner;
    logic [1:0]        disp_client;
    logic [15:0]       client_digits;
    logic [3:0]        client_dp;
    logic [3:0]        lead_blank;
    logic [3:0]        cur_bcd;
    logic              cur_dp;
    logic [7:0]        seg_out;

    // Next requesting client after cur, ascending with wrap; CL_NONE as cur yields the lowest.
    function automatic logic [1:0] next_req(input logic [1:0] cur, input logic [2:0] r);
        logic [1:0] c;
        logic [1:0] res;
        res = CL_NONE;
        c   = cur;
        for (int k = 0; k < 3; k++) begin
            c = (c == 2'd2) ? 2'd0 : c + 2'd1;
            if (res == CL_NONE && r[c]) res = c;
        end
        return res;
    endfunction

    assign scan_tick  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign ms_tick    = (ms_cnt == MS_W'(MS_DIV - 1));
    assign alert_rise = alert & ~alert_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            ms_cnt   <= '0;
        end else begin
            scan_cnt <= scan_tick ? '0 : scan_cnt + SCAN_W'(1);
            ms_cnt   <= ms_tick ? '0 : ms_cnt + MS_W'(1);
        end
    end

    always_comb begin
        if (sw_owner == SW_AUTO) begin
            entry_state = ST_AUTO;
            entry_tgt   = next_req(CL_NONE, req);
        end else begin
            entry_state = ST_MANUAL;
            entry_tgt   = req[sw_owner] ? sw_owner : CL_NONE;
        end
    end

    // Ownership FSM: tgt is the pending owner, committed by the scan stage at frame boundaries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            tgt      <= CL_NONE;
            rot_cnt  <= '0;
            hold_cnt <= '0;
            alert_q  <= 1'b0;
        end else begin
            alert_q <= alert;
            if (alert_rise) begin
                state    <= ST_PREEMPT;
                tgt      <= CL_ALERT;
                hold_cnt <= HOLD_W'(HOLD_MS);
                rot_cnt  <= '0;
            end else begin
                case (state)
                    ST_IDLE, ST_MANUAL: begin
                        state   <= entry_state;
                        tgt     <= entry_tgt;
                        rot_cnt <= '0;
                    end
                    ST_AUTO: begin
                        if (sw_owner != SW_AUTO) begin
                            state   <= entry_state;
                            tgt     <= entry_tgt;
                            rot_cnt <= '0;
                        end else if (req == 3'b000) begin
                            tgt     <= CL_NONE;
                            rot_cnt <= '0;
                        end else if (tgt == CL_NONE || !req[tgt]) begin
                            tgt     <= next_req(tgt, req);
                            rot_cnt <= '0;
                        end else if (ms_tick) begin
                            if (rot_cnt == ROT_W'(ROTATE_MS - 1)) begin
                                tgt     <= next_req(tgt, req);
                                rot_cnt <= '0;
                            end else begin
                                rot_cnt <= rot_cnt + ROT_W'(1);
                            end
                        end
                    end
                    ST_PREEMPT: begin
                        if (hold_cnt == '0) begin
                            state   <= entry_state;
                            tgt     <= entry_tgt;
                            rot_cnt <= '0;
                        end else if (ms_tick) begin
                            hold_cnt <= hold_cnt - HOLD_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign idx_nxt     = idx + 2'd1;
    assign disp_client = (idx == 2'd3) ? tgt : owner;

    always_comb begin
        case (disp_client)
            CL_SW: begin
                client_digits = digits[15:0];
                client_dp     = dp[3:0];
            end
            CL_WATCH: begin
                client_digits = digits[31:16];
                client_dp     = dp[7:4];
            end
            CL_ALERT: begin
                client_digits = digits[47:32];
                client_dp     = dp[11:8];
            end
            default: begin
                client_digits = '0;
                client_dp     = '0;
            end
        endcase
    end

`ifdef FND_BLANK_LEADING_ZERO_EN
    always_comb begin
        lead_blank    = 4'b0000;
        lead_blank[3] = (client_digits[15:12] == 4'd0) && !client_dp[3];
        lead_blank[2] = lead_blank[3] && (client_digits[11:8] == 4'd0) && !client_dp[2];
        lead_blank[1] = lead_blank[2] && (client_digits[7:4] == 4'd0) && !client_dp[1];
    end
`else
    assign lead_blank = 4'b0000;
`endif

    assign cur_bcd = client_digits[{idx_nxt, 2'b00} +: 4];
    assign cur_dp  = client_dp[idx_nxt];

    fnd_seg_encoder u_seg_encoder (
        .bcd   (cur_bcd),
        .dp    (cur_dp),
        .blank (lead_blank[idx_nxt]),
        .seg   (seg_out)
    );

    // Scan stage: owner only changes on the 3->0 wrap so a frame never mixes clients.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= 2'd0;
            owner    <= CL_NONE;
            grant    <= 3'b000;
            fnd_com  <= 4'hF;
            fnd_data <= SEG_BLANK;
        end else begin
            if (scan_tick) idx <= idx_nxt;
            if (tgt == CL_NONE) begin
                owner    <= CL_NONE;
                grant    <= 3'b000;
                fnd_com  <= 4'hF;
                fnd_data <= SEG_BLANK;
            end else if (scan_tick) begin
                if (idx == 2'd3) begin
                    owner    <= tgt;
                    grant    <= client_onehot(tgt);
                    fnd_com  <= 4'b1110;
                    fnd_data <= seg_out;
                end else if (owner != CL_NONE) begin
                    fnd_com  <= ~(4'b0001 << idx_nxt);
                    fnd_data <= seg_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_fnd_share_arbiter.sv
// Scoreboard bench for fnd_share_arbiter: a time-based reference model queues expected outputs, a monitor compares.
module tb_fnd_share_arbiter;

    localparam int ROT  = 8;
    localparam int HOLD = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  sw_owner;
    logic [2:0]  req;
    logic        alert;
    logic [47:0] digits;
    logic [11:0] dp;
    logic [2:0]  grant;
    logic [3:0]  fnd_com;
    logic [7:0]  fnd_data;

    fnd_share_arbiter #(
        .CLK_HZ    (1000),
        .SCAN_HZ   (250),
        .ROTATE_MS (ROT),
        .HOLD_MS   (HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_owner (sw_owner),
        .req      (req),
        .alert    (alert),
        .digits   (digits),
        .dp       (dp),
        .grant    (grant),
        .fnd_com  (fnd_com),
        .fnd_data (fnd_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] grant;
        logic [3:0] com;
        logic [7:0] data;
    } exp_t;

    exp_t expq[$];
    int   checks   = 0;
    int   failures = 0;

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, req_v);
        end
    endtask

    // Client c reachable after cur, ascending with wrap; cur = -1 gives the lowest requester.
    function automatic int first_after(input int cur, input logic [2:0] r);
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (cur + k) % 3;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [7:0] expect_seg(input int c, input int i,
                                              input logic [47:0] dg, input logic [11:0] d);
        logic [15:0] w;
        logic [3:0]  v;
        w = dg[16*c +: 16];
        v = w[4*i +: 4];
`ifdef FND_BLANK_LEADING_ZERO_EN
        if (i > 0) begin
            bit lz;
            lz = 1'b1;
            for (int j = i; j <= 3; j++)
                if (w[4*j +: 4] != 4'd0 || d[4*c+j]) lz = 1'b0;
            if (lz) return 8'hFF;
        end
`endif
        return {~d[4*c+i], seg_tab[v][6:0]};
    endfunction

    // Reference model state: edge count since reset, deadlines instead of counters.
    int   n;
    int   m_tgt;
    int   m_owner;
    int   prev_tgt;
    int   hold_exit;
    int   rot_next;
    int   ph;
    bit   m_preempt;
    bit   m_auto;
    bit   m_prev_alert;
    exp_t m_out;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                n = 0; m_tgt = -1; m_owner = -1; m_preempt = 0; m_auto = 0; m_prev_alert = 0;
                hold_exit = 0; rot_next = 0;
                m_out.grant = 3'b000; m_out.com = 4'hF; m_out.data = 8'hFF;
                expq.delete();
            end else begin
                n++;
                prev_tgt = m_tgt;
                if (alert && !m_prev_alert) begin
                    m_preempt = 1; hold_exit = n + HOLD + 1; m_tgt = 2; m_auto = 0;
                end else if (m_preempt && n < hold_exit) begin
                    m_tgt = 2;
                end else begin
                    m_preempt = 0;
                    if (sw_owner == 2'd3) begin
                        if (!m_auto) begin
                            m_auto = 1; m_tgt = first_after(-1, req); rot_next = n + ROT;
                        end else if (req == 3'b000) begin
                            m_tgt = -1;
                        end else if (m_tgt < 0 || !req[m_tgt]) begin
                            m_tgt = first_after(m_tgt, req); rot_next = n + ROT;
                        end else if (n >= rot_next) begin
                            m_tgt = first_after(m_tgt, req); rot_next = n + ROT;
                        end
                    end else begin
                        m_auto = 0;
                        m_tgt  = req[sw_owner] ? int'(sw_owner) : -1;
                    end
                end
                m_prev_alert = alert;

                if (prev_tgt < 0) begin
                    m_owner = -1;
                    m_out.grant = 3'b000; m_out.com = 4'hF; m_out.data = 8'hFF;
                end else if (n % 4 == 0) begin
                    ph = (n / 4) % 4;
                    if (ph == 0) begin
                        m_owner     = prev_tgt;
                        m_out.grant = 3'b001 << prev_tgt;
                        m_out.com   = 4'b1110;
                        m_out.data  = expect_seg(prev_tgt, 0, digits, dp);
                    end else if (m_owner >= 0) begin
                        m_out.com  = ~(4'b0001 << ph);
                        m_out.data = expect_seg(m_owner, ph, digits, dp);
                    end
                end
                expq.push_back(m_out);
            end
        end
    end

    exp_t got;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && expq.size() > 0) begin
                got = expq.pop_front();
                chk("grant", {5'b0, grant}, {5'b0, got.grant});
                chk("fnd_com", {4'b0, fnd_com}, {4'b0, got.com});
                chk("fnd_data", fnd_data, got.data);
            end
        end
    end

    task automatic run(input int cyc);
        repeat (cyc) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; sw_owner = 2'd0; req = 3'b000; alert = 1'b0; digits = '0; dp = '0;
        run(2);
        chk("reset_grant", {5'b0, grant}, 8'h00);
        chk("reset_com", {4'b0, fnd_com}, 8'h0F);
        chk("reset_data", fnd_data, 8'hFF);
        rst = 1'b0;

        // Manual scan of client 1 showing 1234
        sw_owner = 2'd1; req = 3'b010; digits = {16'h5678, 16'h1234, 16'h9A0B};
        run(40);
        dp = 12'h0A0;
        run(20);

        // Auto rotate between clients 0 and 2, then drop client 2
        dp = '0; sw_owner = 2'd3; req = 3'b101;
        run(70);
        req = 3'b001;
        run(30);
        req = 3'b000;
        run(10);
        req = 3'b111;
        run(50);

        // Preempt with retrigger
        sw_owner = 2'd0; req = 3'b001;
        run(20);
        alert = 1'b1; run(1); alert = 1'b0; run(7);
        alert = 1'b1; run(1); alert = 1'b0;
        run(50);

        // Alert edge together with a sw_owner change
        req = 3'b011; sw_owner = 2'd1; alert = 1'b1;
        run(1); alert = 1'b0;
        run(50);

        // Leading zero content on client 0
        sw_owner = 2'd0; req = 3'b001; digits = {16'h0000, 16'h0000, 16'h0070};
        run(40);
        digits[15:0] = 16'h0000; dp[0] = 1'b1;
        run(20);
        dp[0] = 1'b0; dp[2] = 1'b1;
        run(20);

        // Asynchronous reset mid-frame
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("midrst_grant", {5'b0, grant}, 8'h00);
        chk("midrst_com", {4'b0, fnd_com}, 8'h0F);
        chk("midrst_data", fnd_data, 8'hFF);
        run(2);
        rst = 1'b0;

        for (int k = 0; k < 2500; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) sw_owner = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 11) == 0) req = 3'($urandom);
            if ($urandom_range(0, 29) == 0) alert = ~alert;
            if ($urandom_range(0, 7) == 0) begin
                digits = {16'($urandom), 32'($urandom)};
                dp     = 12'($urandom) & 12'($urandom);
                if ($urandom_range(0, 2) == 0) begin
                    digits = digits & {3{16'h00FF}};
                    dp     = dp & 12'h333;
                end
            end
        end
        run(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
